irq_timer: RTL
==============

# irq_timer

Programmable interrupt source on the 6502 peripheral bus. It uses the same two-address command/data register scheme as the interrupt controller. A 16-bit down-counter is clocked through an 8-bit prescaler. On expiry the block drives one `int_in` line of the interrupt controller, either as a one-cycle pulse (for edge-typed inputs) or as a held level (for level-typed inputs).

## Interface
- `RESET_RELOAD`, default 16'hFFFF: reload register value after reset.
- `RESET_PRESCALE`, default 8'h00: prescale register value after reset.

- `clk`  in  1  system clock; all state updates on the falling edge.
- `reset`  in  1  synchronous, active-high.
- `i_data`  in  8  bus write data.
- `o_data`  out  8  bus read data (combinational).
- `addr`  in  1  0 = command register, 1 = data port.
- `cs`  in  1  chip select.
- `rwb`  in  1  1 = read, 0 = write.
- `int_out`  out  1  interrupt request to one controller `int_in` bit.

## Operation
- Bus strobes: `we = cs & ~rwb`, `re = cs & rwb`.
- A write with `addr=0` loads `cmd`. A read with `addr=0` returns `cmd`.
- A data access (`addr=1`) targets the register selected by `cmd`:
  - 8'h00 CTRL (rw): bit0 EN, bit1 PERIODIC, bit2 LEVEL, bit3 IRQ_EN. Bits 7:4 read 0.
  - 8'h01 STATUS: read returns bit0 EXPIRED (sticky), bit1 RUNNING. Writing 1 to bit0 clears EXPIRED (ack); writing 0 has no effect.
  - 8'h02 PRESCALE (rw).
  - 8'h03 RELOAD_LO (rw).
  - 8'h04 RELOAD_HI (rw).
  - 8'h05 COUNT_LO (ro): returns live `count[7:0]` and copies `count[15:8]` into `shadow_hi` at the same edge.
  - 8'h06 COUNT_HI (ro): returns `shadow_hi`.
  - Any other cmd: reads return 8'h00, writes are ignored.
- Start: a CTRL write that changes EN from 0 to 1 loads `count <= reload` and `pscnt <= prescale`, and sets RUNNING.
- Tick: when RUNNING and `pscnt == 0`, set `pscnt <= prescale` and pulse `tick`. Otherwise, while RUNNING, decrement `pscnt`.
- On tick:
  - If `count != 0`: `count <= count - 1`.
  - If `count == 0` (expiry): set EXPIRED.
    - If PERIODIC: `count <= reload`.
    - Otherwise: clear RUNNING and EN, and `count` holds at 0.
- Expiry period is (prescale+1)*(reload+1) clocks. Reload 0 with prescale 0 expires every cycle.
- A CTRL write with EN=0 clears RUNNING. `count` and `pscnt` freeze and are not reloaded until the next 0→1 EN transition.
- Interrupt output:
  - LEVEL=1: `int_out = EXPIRED & IRQ_EN`.
  - LEVEL=0: `int_out` is high for exactly one cycle after each expiry edge, only when IRQ_EN=1. EXPIRED is still set for polling.
- Writes to RELOAD_* while running take effect at the next reload only. They do not change the current `count`.

## Timing
- All registers update on the negedge of `clk`. `o_data` and `int_out` are combinational from registered state.
- Reset values: `cmd`=0, CTRL=0, EXPIRED=0, RUNNING=0, `count`=0, `pscnt`=0, `shadow_hi`=0, `reload`=RESET_RELOAD, `prescale`=RESET_PRESCALE, `int_out`=0, `o_data`=8'h00 (cmd 0 selects CTRL=0).
- Reset asserted mid-count aborts the count immediately. No interrupt is generated in that cycle.
- Latency from the expiry edge to `int_out` high is 0 cycles, as seen after that negedge.
- Simultaneous expiry and STATUS ack in the same edge: set wins, so EXPIRED stays 1.
- Simultaneous EN 0→1 write and a tick: the start load wins.
- A `cmd` write and a data access cannot coincide, since `addr` is a single bit.
- Count wrap: `count` never underflows. Reaching 0 triggers expiry, not a wrap to 16'hFFFF.

## Structure
- Package `irq_timer_pkg` holds:
  - cmd constants `CMD_CTRL` … `CMD_COUNT_HI`.
  - CTRL bit indices `CTRL_EN`, `CTRL_PERIODIC`, `CTRL_LEVEL`, `CTRL_IRQ_EN`.
  - STATUS bit indices.
- Sub-module `tick_divider`: 8-bit reloadable prescaler. Inputs are `clk`, `reset`, `run`, `load`, `prescale`; output is the `tick` pulse.
- The top level holds the bus decode, the counter, the flags and the IRQ output logic.

## Test plan
- Reset, then read CTRL and STATUS → both 8'h00, `int_out`=0, RELOAD_LO/HI read 8'hFF/8'hFF.
- One-shot, prescale=0, reload=3, CTRL=8'h09 (EN, IRQ_EN, pulse) → `int_out` is a single-cycle pulse 4 cycles after the enable edge. EN then reads 0, EXPIRED=1, RUNNING=0.
- Periodic level mode, prescale=1, reload=4, CTRL=8'h0F → first expiry 10 cycles after enable. `int_out` stays high until STATUS is written with 8'h01, then goes low. It rises again 10 cycles after the previous expiry.
- Ack written in the same cycle as an expiry → EXPIRED remains 1 and `int_out` remains high (level mode).
- Atomic read with reload=16'h0100, prescale=0: read COUNT_LO while count=16'h0100 → 8'h00. Subsequent COUNT_HI after further ticks → 8'h01 (shadow), not the live value.
- Reset asserted mid-count, and EN cleared mid-count → `count` freezes. Re-enable reloads from RELOAD, and no stale interrupt occurs.

Source files
------------

// File: rtl/irq_timer_pkg.sv
// irq_timer_pkg: register map and bit indices shared by the interrupt timer files.
package irq_timer_pkg;
  typedef logic [7:0] cmd_t;
  localparam cmd_t CMD_CTRL      = 8'h00;
  localparam cmd_t CMD_STATUS    = 8'h01;
  localparam cmd_t CMD_PRESCALE  = 8'h02;
  localparam cmd_t CMD_RELOAD_LO = 8'h03;
  localparam cmd_t CMD_RELOAD_HI = 8'h04;
  localparam cmd_t CMD_COUNT_LO  = 8'h05;
  localparam cmd_t CMD_COUNT_HI  = 8'h06;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_LEVEL    = 2;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int STAT_EXPIRED  = 0;
  localparam int STAT_RUNNING  = 1;
endpackage

// File: rtl/irq_timer_tick_divider.sv
// tick_divider: 8-bit reloadable prescaler emitting one tick every prescale+1 running clocks.
module tick_divider (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] prescale,
  output logic       tick
);
  logic [7:0] r_pscnt;
  assign tick = run & ~load & (r_pscnt == 8'd0);
  always_ff @(negedge clk) begin
    if (reset) r_pscnt <= '0;
    else if (load) r_pscnt <= prescale;
    else if (run) r_pscnt <= tick ? prescale : r_pscnt - 8'd1;
  end
endmodule

// File: rtl/irq_timer.sv
// irq_timer: bus-programmed 16-bit down-counter raising a pulse or level interrupt on expiry.
module irq_timer
  import irq_timer_pkg::*;
#(
  parameter logic [15:0] RESET_RELOAD   = 16'hFFFF,
  parameter logic [7:0]  RESET_PRESCALE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  input  logic       addr,
  input  logic       cs,
  input  logic       rwb,
  output logic       int_out
);
  logic [7:0]  r_cmd, r_prescale, r_shadow_hi, w_rdata;
  logic [3:0]  r_ctrl;
  logic [15:0] r_count, r_reload;
  logic        r_expired, r_running, r_pulse;
  logic        w_we, w_dwe, w_dre, w_ctrl_wr, w_start, w_tick, w_expire, w_periodic;
  assign w_we       = cs & ~rwb;
  assign w_dwe      = w_we & addr;
  assign w_dre      = cs & rwb & addr;
  assign w_ctrl_wr  = w_dwe & (r_cmd == CMD_CTRL);
  assign w_start    = w_ctrl_wr & i_data[CTRL_EN] & ~r_ctrl[CTRL_EN];
  assign w_expire   = w_tick & (r_count == 16'd0);
  assign w_periodic = r_ctrl[CTRL_PERIODIC];
  tick_divider u_div (
    .clk(clk), .reset(reset), .run(r_running), .load(w_start),
    .prescale(r_prescale), .tick(w_tick)
  );
  always_ff @(negedge clk) begin
    if (reset) begin
      r_cmd       <= '0;
      r_ctrl      <= '0;
      r_prescale  <= RESET_PRESCALE;
      r_reload    <= RESET_RELOAD;
      r_count     <= '0;
      r_shadow_hi <= '0;
      r_expired   <= 1'b0;
      r_running   <= 1'b0;
      r_pulse     <= 1'b0;
    end else begin
      if (w_we & ~addr) r_cmd <= i_data;
      if (w_dwe & (r_cmd == CMD_PRESCALE)) r_prescale <= i_data;
      if (w_dwe & (r_cmd == CMD_RELOAD_LO)) r_reload[7:0] <= i_data;
      if (w_dwe & (r_cmd == CMD_RELOAD_HI)) r_reload[15:8] <= i_data;
      if (w_dre & (r_cmd == CMD_COUNT_LO)) r_shadow_hi <= r_count[15:8];
      r_pulse <= w_expire & r_ctrl[CTRL_IRQ_EN];
      if (w_dwe & (r_cmd == CMD_STATUS) & i_data[STAT_EXPIRED]) r_expired <= 1'b0;
      if (w_expire) r_expired <= 1'b1;
      if (w_tick) r_count <= (r_count != 16'd0) ? r_count - 16'd1 : (w_periodic ? r_reload : r_count);
      if (w_expire & ~w_periodic) begin
        r_running        <= 1'b0;
        r_ctrl[CTRL_EN]  <= 1'b0;
      end
      // EN 1->1 keeps the current run state, 0->1 starts, EN=0 stops
      if (w_ctrl_wr) begin
        r_ctrl    <= i_data[3:0];
        r_running <= i_data[CTRL_EN] & (r_running | ~r_ctrl[CTRL_EN]);
      end
      if (w_start) r_count <= r_reload;
    end
  end
  always_comb begin
    w_rdata = '0;
    case (r_cmd)
      CMD_CTRL:      w_rdata = {4'b0, r_ctrl};
      CMD_STATUS:    w_rdata = {6'b0, r_running, r_expired};
      CMD_PRESCALE:  w_rdata = r_prescale;
      CMD_RELOAD_LO: w_rdata = r_reload[7:0];
      CMD_RELOAD_HI: w_rdata = r_reload[15:8];
      CMD_COUNT_LO:  w_rdata = r_count[7:0];
      CMD_COUNT_HI:  w_rdata = r_shadow_hi;
      default:       w_rdata = '0;
    endcase
  end
  assign o_data  = addr ? w_rdata : r_cmd;
  assign int_out = r_ctrl[CTRL_LEVEL] ? (r_expired & r_ctrl[CTRL_IRQ_EN]) : r_pulse;
endmodule
